bpu_resolve_ctrl: RTL and testbench

BPU_RESOLVE_CTRL -- requirements
Module: bpu_resolve_ctrl

---
 rtl/bpu_resolve_ctrl_if.sv | 46 ++++
 rtl/bpu_resolve_ctrl.sv | 125 ++++++++++++
 tb/tb_bpu_resolve_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bpu_resolve_ctrl_if.sv
// Fetch/execute-facing bundle for the branch-resolution queue.
// Optional stat_hit/stat_miss counters exist only when ZCRV_BPU_STAT_EN is defined.
interface bpu_resolve_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alloc_vld;
  logic [AW-1:0] alloc_pc;
  logic          alloc_bxx;
  logic          alloc_taken;
  logic          alloc_rdy;
  logic          res_vld;
  logic          res_taken;
  logic [AW-1:0] fix_pc;
  logic          presuccess;
  logic          prefail;
  logic          flush;
  logic [CW-1:0] count;
  logic          res_err;
`ifdef ZCRV_BPU_STAT_EN
  logic [15:0]   stat_hit;
  logic [15:0]   stat_miss;

  modport master (
    output alloc_vld, alloc_pc, alloc_bxx, alloc_taken, res_vld, res_taken,
    input  alloc_rdy, fix_pc, presuccess, prefail, flush, count, res_err,
    input  stat_hit, stat_miss
  );
  modport slave (
    input  alloc_vld, alloc_pc, alloc_bxx, alloc_taken, res_vld, res_taken,
    output alloc_rdy, fix_pc, presuccess, prefail, flush, count, res_err,
    output stat_hit, stat_miss
  );
`else
  modport master (
    output alloc_vld, alloc_pc, alloc_bxx, alloc_taken, res_vld, res_taken,
    input  alloc_rdy, fix_pc, presuccess, prefail, flush, count, res_err
  );
  modport slave (
    input  alloc_vld, alloc_pc, alloc_bxx, alloc_taken, res_vld, res_taken,
    output alloc_rdy, fix_pc, presuccess, prefail, flush, count, res_err
  );
`endif
endinterface

// File: rtl/bpu_resolve_ctrl.sv
// In-flight branch prediction queue: resolves the oldest entry, drives PHT update pulses and flush.
// Define ZCRV_BPU_STAT_EN to add saturating hit/miss counters.
module bpu_resolve_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input logic             clk,
  input logic             rst,
  bpu_resolve_ctrl_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state, state_next;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [AW-1:0] fix_pc;
  logic          presuccess, prefail, flush, res_err;

  logic [AW-1:0] pc_mem    [DEPTH];
  logic          bxx_mem   [DEPTH];
  logic          taken_mem [DEPTH];

  logic rdy, enq, deq, mispredict, hit, err_set;

  always_comb begin
    state_next = state;
    rdy        = (state == RUN) && (count < CW'(DEPTH));
    deq        = 1'b0;
    mispredict = 1'b0;
    hit        = 1'b0;
    err_set    = 1'b0;
    enq        = 1'b0;
    case (state)
      RUN: begin
        if (bus.res_vld) begin
          if (count == '0) begin
            err_set = 1'b1;
          end else begin
            deq        = 1'b1;
            mispredict = bxx_mem[head] && (bus.res_taken != taken_mem[head]);
            hit        = bxx_mem[head] && (bus.res_taken == taken_mem[head]);
          end
        end
        // A mispredict empties the queue, so a same-cycle enqueue is dropped.
        enq = bus.alloc_vld && rdy && !mispredict;
        if (mispredict) state_next = FLUSH;
      end
      FLUSH: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fix_pc     <= '0;
      presuccess <= 1'b0;
      prefail    <= 1'b0;
      flush      <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      state      <= state_next;
      presuccess <= hit;
      prefail    <= mispredict;
      flush      <= mispredict;
      if (deq)     fix_pc  <= pc_mem[head];
      if (err_set) res_err <= 1'b1;
      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (deq) head <= head + 1'b1;
        if (enq) tail <= tail + 1'b1;
        if (enq && !deq)      count <= count + 1'b1;
        else if (!enq && deq) count <= count - 1'b1;
      end
    end
  end

  // Storage holds no reset: occupancy is tracked purely by head/tail/count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (enq && (tail == PW'(gi))) begin
          pc_mem[gi]    <= bus.alloc_pc;
          bxx_mem[gi]   <= bus.alloc_bxx;
          taken_mem[gi] <= bus.alloc_taken;
        end
      end
    end
  endgenerate

`ifdef ZCRV_BPU_STAT_EN
  logic [15:0] stat_hit, stat_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else begin
      if (hit && (stat_hit != 16'hFFFF))         stat_hit  <= stat_hit + 16'd1;
      if (mispredict && (stat_miss != 16'hFFFF)) stat_miss <= stat_miss + 16'd1;
    end
  end

  assign bus.stat_hit  = stat_hit;
  assign bus.stat_miss = stat_miss;
`endif

  assign bus.alloc_rdy  = rdy;
  assign bus.fix_pc     = fix_pc;
  assign bus.presuccess = presuccess;
  assign bus.prefail    = prefail;
  assign bus.flush      = flush;
  assign bus.count      = count;
  assign bus.res_err    = res_err;
endmodule

// File: tb/tb_bpu_resolve_ctrl.sv
// Self-checking bench for bpu_resolve_ctrl: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_bpu_resolve_ctrl;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  typedef struct {
    logic [31:0] pc;
    logic        bxx;
    logic        taken;
  } ent_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bpu_resolve_ctrl_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  bpu_resolve_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [2:0] pulses = {bus.presuccess, bus.prefail, bus.flush};

  task automatic tick(input logic av, input logic [31:0] pc, input logic bxx,
                      input logic tk, input logic rv, input logic rt);
    bus.alloc_vld   = av;
    bus.alloc_pc    = pc;
    bus.alloc_bxx   = bxx;
    bus.alloc_taken = tk;
    bus.res_vld     = rv;
    bus.res_taken   = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    total++; if (bus.alloc_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", bus.alloc_rdy); end
    total++; if (pulses !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", pulses); end
    total++; if (bus.fix_pc !== 32'h0) begin bad++; $display("FAIL reset_fix_pc got=%h exp=0", bus.fix_pc); end
    total++; if (bus.res_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.res_err); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      tick(1, 32'h100 + 32'(4 * i), 1, 1, 0, 0);
      total++; if (bus.count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", bus.count, i + 1); end
    end
    total++; if (bus.alloc_rdy !== 1'b0) begin bad++; $display("FAIL full_rdy got=%b exp=0", bus.alloc_rdy); end
  endtask

  task automatic test_hit();
    tick(0, 0, 0, 0, 1, 1);
    total++; if (pulses !== 3'b100) begin bad++; $display("FAIL hit_pulses got=%b exp=100", pulses); end
    total++; if (bus.fix_pc !== 32'h100) begin bad++; $display("FAIL hit_fix_pc got=%h exp=100", bus.fix_pc); end
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL hit_count got=%0d exp=3", bus.count); end
    // simultaneous enqueue + correct dequeue keeps occupancy
    tick(1, 32'h110, 1, 1, 1, 1);
    total++; if ({pulses, bus.count} !== {3'b100, 3'd3}) begin bad++; $display("FAIL back_to_back got=%b/%0d exp=100/3", pulses, bus.count); end
    total++; if (bus.fix_pc !== 32'h104) begin bad++; $display("FAIL b2b_fix_pc got=%h exp=104", bus.fix_pc); end
    tick(1, 32'h114, 1, 1, 0, 0);
    // full: enqueue blocked even though a dequeue happens this cycle
    tick(1, 32'h118, 1, 1, 1, 1);
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL full_block_count got=%0d exp=3", bus.count); end
    total++; if (bus.fix_pc !== 32'h108) begin bad++; $display("FAIL full_block_fix got=%h exp=108", bus.fix_pc); end
  endtask

  task automatic test_mispredict();
    tick(1, 32'h120, 1, 1, 1, 0);
    total++; if (pulses !== 3'b011) begin bad++; $display("FAIL misp_pulses got=%b exp=011", pulses); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL misp_count got=%0d exp=0", bus.count); end
    total++; if (bus.alloc_rdy !== 1'b0) begin bad++; $display("FAIL misp_rdy got=%b exp=0", bus.alloc_rdy); end
    total++; if (bus.fix_pc !== 32'h10C) begin bad++; $display("FAIL misp_fix_pc got=%h exp=10c", bus.fix_pc); end
    // during FLUSH both alloc and res are ignored
    tick(1, 32'h124, 1, 1, 1, 0);
    total++; if ({pulses, bus.count, bus.alloc_rdy, bus.res_err} !== {3'b000, 3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL flush_cycle got=%b/%0d/%b/%b exp=000/0/1/0", pulses, bus.count, bus.alloc_rdy, bus.res_err);
    end
  endtask

  task automatic test_jal();
    tick(1, 32'h200, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    total++; if (pulses !== 3'b000) begin bad++; $display("FAIL jal_pulses got=%b exp=000", pulses); end
    total++; if (bus.fix_pc !== 32'h200) begin bad++; $display("FAIL jal_fix_pc got=%h exp=200", bus.fix_pc); end
    total++; if ({bus.count, bus.alloc_rdy} !== {3'd0, 1'b1}) begin bad++; $display("FAIL jal_state got=%0d/%b exp=0/1", bus.count, bus.alloc_rdy); end
  endtask

  task automatic test_res_err();
    tick(0, 0, 0, 0, 1, 1);
    total++; if (bus.res_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", bus.res_err); end
    total++; if ({pulses, bus.count, bus.fix_pc} !== {3'b000, 3'd0, 32'h200}) begin
      bad++; $display("FAIL err_nochange got=%b/%0d/%h exp=000/0/200", pulses, bus.count, bus.fix_pc);
    end
    for (int i = 0; i < 3; i++) tick(1, 32'h300 + 32'(4 * i), 1, 1, 0, 0);
    total++; if ({bus.res_err, bus.count} !== {1'b1, 3'd3}) begin bad++; $display("FAIL err_sticky got=%b/%0d exp=1/3", bus.res_err, bus.count); end
    rst = 1'b1;
    #1;
    total++; if ({bus.count, bus.res_err, bus.fix_pc} !== {3'd0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL async_rst got=%0d/%b/%h exp=0/0/0", bus.count, bus.res_err, bus.fix_pc);
    end
    #1 rst = 1'b0;
    tick(0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 0, 0);
    total++; if ({pulses, bus.count} !== {3'b000, 3'd0}) begin bad++; $display("FAIL post_rst got=%b/%0d exp=000/0", pulses, bus.count); end
    // reset in the middle of a flush
    tick(1, 32'h400, 1, 1, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    #1;
    total++; if ({pulses, bus.alloc_rdy, bus.count} !== {3'b000, 1'b1, 3'd0}) begin
      bad++; $display("FAIL rst_mid_flush got=%b/%b/%0d exp=000/1/0", pulses, bus.alloc_rdy, bus.count);
    end
    #1 rst = 1'b0;
    tick(0, 0, 0, 0, 0, 0);
    total++; if (pulses !== 3'b000) begin bad++; $display("FAIL after_flush_rst got=%b exp=000", pulses); end
  endtask

`ifdef ZCRV_BPU_STAT_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 32'h500 + 32'(4 * i), 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 1, 1);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 0);
    total++; if (bus.stat_hit !== 16'd3) begin bad++; $display("FAIL stat_hit got=%0d exp=3", bus.stat_hit); end
    total++; if (bus.stat_miss !== 16'd1) begin bad++; $display("FAIL stat_miss got=%0d exp=1", bus.stat_miss); end
  endtask
`endif

  task automatic test_random();
    ent_t        mq[$];
    ent_t        h;
    ent_t        e;
    bit          m_flushing, m_err, exp_rdy;
    logic [2:0]  m_pulse;
    logic [31:0] m_fix;
    int          m_hit, m_miss;
    logic        av, bxx, tk, rv, rt;
    logic [31:0] pc;
    do_reset();
    m_flushing = 0; m_err = 0; m_fix = 0; m_hit = 0; m_miss = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      av  = ($urandom_range(0, 9) < 7);
      pc  = $urandom & 32'hFFFF_FFFC;
      bxx = ($urandom_range(0, 3) != 0);
      tk  = 1'($urandom);
      rv  = ($urandom_range(0, 9) < 4);
      if (mq.size() > 0) rt = ($urandom_range(0, 7) == 0) ? !mq[0].taken : mq[0].taken;
      else               rt = 1'($urandom);
      exp_rdy = !m_flushing && (mq.size() < DEPTH);
      total++; if (bus.alloc_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", cyc, bus.alloc_rdy, exp_rdy); end
      e.pc = pc; e.bxx = bxx; e.taken = tk;
      m_pulse = 3'b000;
      if (m_flushing) begin
        m_flushing = 0;
      end else begin
        if (rv && mq.size() == 0) m_err = 1;
        if (rv && mq.size() > 0) begin
          h = mq.pop_front();
          m_fix = h.pc;
          if (h.bxx && (rt != h.taken)) begin
            mq.delete();
            m_pulse = 3'b011;
            m_flushing = 1;
            m_miss++;
          end else begin
            if (h.bxx) begin m_pulse = 3'b100; m_hit++; end
            if (av && exp_rdy) mq.push_back(e);
          end
        end else if (av && exp_rdy) begin
          mq.push_back(e);
        end
      end
      tick(av, pc, bxx, tk, rv, rt);
      total++; if (pulses !== m_pulse) begin bad++; $display("FAIL rnd_pulses cyc=%0d got=%b exp=%b", cyc, pulses, m_pulse); end
      total++; if (bus.count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, bus.count, mq.size()); end
      total++; if (bus.fix_pc !== m_fix) begin bad++; $display("FAIL rnd_fix_pc cyc=%0d got=%h exp=%h", cyc, bus.fix_pc, m_fix); end
      total++; if (bus.res_err !== m_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bus.res_err, m_err); end
`ifdef ZCRV_BPU_STAT_EN
      total++; if ({bus.stat_hit, bus.stat_miss} !== {16'(m_hit), 16'(m_miss)}) begin
        bad++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, bus.stat_hit, bus.stat_miss, m_hit, m_miss);
      end
`endif
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.alloc_vld = 0; bus.alloc_pc = 0; bus.alloc_bxx = 0;
    bus.alloc_taken = 0; bus.res_vld = 0; bus.res_taken = 0;
    test_reset();
    test_fill();
    test_hit();
    test_mispredict();
    test_jal();
    test_res_err();
`ifdef ZCRV_BPU_STAT_EN
    test_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
